hx8352_fill_engine: RTL and testbench

HX8352_FILL_ENGINE -- requirements
Module: hx8352_fill_engine

---
 rtl/hx8352_fill_engine.sv | 193 +++++++++++++++++++
 tb/tb_hx8352_fill_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hx8352_fill_engine.sv
// rtl/hx8352_fill_engine.sv - HX8352 rectangle fill sequencer (window setup, 0x22, pixel stream)
// Optional HX8352_FILL_CLIP_EN: clamp x1/y1 to the panel instead of rejecting the request.
module hx8352_fill_engine #(
   parameter int WIDTH  = 240,
   parameter int HEIGHT = 400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [8:0]  x0,
   input  logic [8:0]  x1,
   input  logic [8:0]  y0,
   input  logic [8:0]  y1,
   input  logic [15:0] color,
   input  logic        init_done,
   input  logic        lcd_busy,
   output logic [7:0]  cmd_out,
   output logic [15:0] data_out,
   output logic        is_cmd,
   output logic        wr_req,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [8:0] C_XMAX = 9'(WIDTH - 1);
   localparam logic [8:0] C_YMAX = 9'(HEIGHT - 1);

   typedef enum logic [2:0] {
      IDLE, CHECK, WIN_CMD, WIN_DATA, MEM_CMD, PIXEL, WAIT, FINISH
   } state_t;

   state_t      r_state;
   state_t      w_next;
   state_t      r_ret;
   state_t      w_ret;
   logic [2:0]  r_idx;
   logic [8:0]  r_col;
   logic [8:0]  r_row;
   logic        r_wait;
   logic [8:0]  r_x0, r_x1, r_y0, r_y1;
   logic [15:0] r_color;
   logic        r_err;

   logic [8:0]  w_x1_eff;
   logic [8:0]  w_y1_eff;
   logic        w_range_bad;
   logic        w_bad;
   logic        w_issue;
   logic        w_last_pix;
   logic [15:0] w_win_data;

`ifdef HX8352_FILL_CLIP_EN
   assign w_x1_eff    = (r_x1 > C_XMAX) ? C_XMAX : r_x1;
   assign w_y1_eff    = (r_y1 > C_YMAX) ? C_YMAX : r_y1;
   assign w_range_bad = 1'b0;
`else
   assign w_x1_eff    = r_x1;
   assign w_y1_eff    = r_y1;
   assign w_range_bad = (r_x1 > C_XMAX) || (r_y1 > C_YMAX);
`endif

   assign w_bad      = (r_x0 > w_x1_eff) || (r_y0 > w_y1_eff) || w_range_bad;
   assign w_last_pix = (r_col == 9'd0) && (r_row == 9'd0);

   // Register pairs 0x02..0x09 carry the high bit then the low byte of each bound.
   always_comb begin
      w_win_data = 16'h0000;
      case (r_idx)
         3'd0: w_win_data = {15'h0000, r_x0[8]};
         3'd1: w_win_data = {8'h00, r_x0[7:0]};
         3'd2: w_win_data = {15'h0000, r_x1[8]};
         3'd3: w_win_data = {8'h00, r_x1[7:0]};
         3'd4: w_win_data = {15'h0000, r_y0[8]};
         3'd5: w_win_data = {8'h00, r_y0[7:0]};
         3'd6: w_win_data = {15'h0000, r_y1[8]};
         default: w_win_data = {8'h00, r_y1[7:0]};
      endcase
   end

   always_comb begin
      w_next   = r_state;
      w_ret    = r_ret;
      w_issue  = 1'b0;
      wr_req   = 1'b0;
      is_cmd   = 1'b0;
      cmd_out  = 8'h00;
      data_out = 16'h0000;
      busy     = (r_state != IDLE) && (r_state != FINISH);
      done     = (r_state == FINISH);
      err      = r_err;
      case (r_state)
         IDLE: begin
            if (start && init_done) w_next = CHECK;
         end
         CHECK: begin
            w_next = w_bad ? IDLE : WIN_CMD;
         end
         WIN_CMD: begin
            is_cmd  = 1'b1;
            cmd_out = 8'h02 + {5'd0, r_idx};
            w_issue = !lcd_busy;
            w_ret   = WIN_DATA;
         end
         WIN_DATA: begin
            data_out = w_win_data;
            w_issue  = !lcd_busy;
            w_ret    = (r_idx == 3'd7) ? MEM_CMD : WIN_CMD;
         end
         MEM_CMD: begin
            is_cmd  = 1'b1;
            cmd_out = 8'h22;
            w_issue = !lcd_busy;
            w_ret   = PIXEL;
         end
         PIXEL: begin
            data_out = r_color;
            w_issue  = !lcd_busy;
            w_ret    = w_last_pix ? FINISH : PIXEL;
         end
         WAIT: begin
            // r_wait marks the second cycle, so WAIT always lasts at least two cycles.
            if (r_wait && !lcd_busy) w_next = r_ret;
         end
         FINISH: begin
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      if (w_issue) begin
         wr_req = 1'b1;
         w_next = WAIT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ret   <= IDLE;
         r_idx   <= 3'd0;
         r_col   <= 9'd0;
         r_row   <= 9'd0;
         r_wait  <= 1'b0;
         r_x0    <= 9'd0;
         r_x1    <= 9'd0;
         r_y0    <= 9'd0;
         r_y1    <= 9'd0;
         r_color <= 16'h0000;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= (r_state == CHECK) && w_bad;
         case (r_state)
            IDLE: begin
               if (start && init_done) begin
                  r_x0    <= x0;
                  r_x1    <= x1;
                  r_y0    <= y0;
                  r_y1    <= y1;
                  r_color <= color;
               end
            end
            CHECK: begin
               r_x1  <= w_x1_eff;
               r_y1  <= w_y1_eff;
               r_col <= w_x1_eff - r_x0;
               r_row <= w_y1_eff - r_y0;
               r_idx <= 3'd0;
            end
            WAIT: begin
               r_wait <= 1'b1;
            end
            default: begin
               if (w_issue) begin
                  r_ret  <= w_ret;
                  r_wait <= 1'b0;
                  if (r_state == WIN_DATA) r_idx <= r_idx + 3'd1;
                  // Column counter reloads on wrap, which steps the row counter.
                  if (r_state == PIXEL && !w_last_pix) begin
                     if (r_col == 9'd0) begin
                        r_col <= r_x1 - r_x0;
                        r_row <= r_row - 9'd1;
                     end else begin
                        r_col <= r_col - 9'd1;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hx8352_fill_engine.sv
// tb/tb_hx8352_fill_engine.sv - table-driven and sequence checks for hx8352_fill_engine
module tb_hx8352_fill_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [8:0]  x0 = 9'd0, x1 = 9'd0, y0 = 9'd0, y1 = 9'd0;
   logic [15:0] color = 16'h0000;
   logic        init_done = 1'b0;
   logic        lcd_busy = 1'b0;
   logic [7:0]  cmd_out;
   logic [15:0] data_out;
   logic        is_cmd, wr_req, busy, done, err;

   hx8352_fill_engine #(.WIDTH(240), .HEIGHT(400)) dut (
      .clk(clk), .rst(rst), .start(start), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
      .color(color), .init_done(init_done), .lcd_busy(lcd_busy), .cmd_out(cmd_out),
      .data_out(data_out), .is_cmd(is_cmd), .wr_req(wr_req), .busy(busy),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0]  x0, x1, y0, y1;
      logic [15:0] color;
      int          exp_err;
      int          exp_xfers;
   } vec_t;

   vec_t        vecs [8];
   int          n_checks = 0;
   int          n_fail = 0;
   int          wr_cnt, done_cnt, err_cnt, viol_cnt, busy_cycles;
   logic [16:0] got_q [$];
   logic [16:0] exp_q [$];
   bit          busy_mode = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: one entry per wr_req cycle, encoded as {is_cmd, value}.
   initial begin
      forever begin
         @(negedge clk);
         if (wr_req) begin
            wr_cnt++;
            if (lcd_busy) viol_cnt++;
            got_q.push_back(is_cmd ? {1'b1, 8'h00, cmd_out} : {1'b0, data_out});
         end
         if (done) done_cnt++;
         if (err) err_cnt++;
         if (busy) busy_cycles++;
      end
   end

   // Controller model: when enabled, stays busy for 5 cycles after every accepted transfer.
   initial begin
      forever begin
         @(negedge clk);
         if (busy_mode && wr_req) begin
            @(posedge clk);
            #1 lcd_busy = 1'b1;
            repeat (5) @(posedge clk);
            #1 lcd_busy = 1'b0;
         end
      end
   end

   task automatic clear_mon();
      wr_cnt = 0; done_cnt = 0; err_cnt = 0; viol_cnt = 0; busy_cycles = 0;
      got_q.delete();
   endtask

   function automatic void build_exp(input logic [8:0] a0, input logic [8:0] a1_in,
                                     input logic [8:0] b0, input logic [8:0] b1_in,
                                     input logic [15:0] c);
      logic [8:0] a1, b1;
      bit bad;
      int npix;
      logic [8:0] vals [4];
      a1 = a1_in; b1 = b1_in; bad = 0;
      exp_q.delete();
`ifdef HX8352_FILL_CLIP_EN
      if (a1 > 9'd239) a1 = 9'd239;
      if (b1 > 9'd399) b1 = 9'd399;
`else
      if (a1 > 9'd239 || b1 > 9'd399) bad = 1;
`endif
      if (a0 > a1 || b0 > b1) bad = 1;
      if (bad) return;
      vals[0] = a0; vals[1] = a1; vals[2] = b0; vals[3] = b1;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({1'b1, 8'h00, 8'h02 + 8'(2 * k)});
         exp_q.push_back({1'b0, 15'h0000, vals[k][8]});
         exp_q.push_back({1'b1, 8'h00, 8'h03 + 8'(2 * k)});
         exp_q.push_back({1'b0, 8'h00, vals[k][7:0]});
      end
      exp_q.push_back({1'b1, 16'h0022});
      npix = (int'(a1) - int'(a0) + 1) * (int'(b1) - int'(b0) + 1);
      for (int p = 0; p < npix; p++) exp_q.push_back({1'b0, c});
   endfunction

   task automatic check_seq(input string name);
      int bad;
      bad = 0;
      if (got_q.size() != exp_q.size()) bad = 1;
      else for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      check(name, bad, 0);
   endtask

   task automatic launch(input logic [8:0] a0, input logic [8:0] a1, input logic [8:0] b0,
                         input logic [8:0] b1, input logic [15:0] c);
      @(posedge clk);
      #1;
      x0 = a0; x1 = a1; y0 = b0; y1 = b1; color = c; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_end(input string name);
      int n;
      n = 0;
      while (done_cnt == 0 && err_cnt == 0 && n < 5000) begin
         @(posedge clk);
         n++;
      end
      check({name, "_timeout"}, (n >= 5000) ? 1 : 0, 0);
      repeat (4) @(posedge clk);
   endtask

   initial begin
      vecs[0] = '{9'd0,   9'd1,   9'd0,   9'd1,   16'hF800, 0, 21};
      vecs[1] = '{9'd10,  9'd5,   9'd0,   9'd0,   16'h07E0, 1, 0};
`ifdef HX8352_FILL_CLIP_EN
      vecs[2] = '{9'd0,   9'd300, 9'd0,   9'd0,   16'h001F, 0, 257};
      vecs[7] = '{9'd239, 9'd239, 9'd399, 9'd400, 16'hAAAA, 0, 18};
`else
      vecs[2] = '{9'd0,   9'd300, 9'd0,   9'd0,   16'h001F, 1, 0};
      vecs[7] = '{9'd239, 9'd239, 9'd399, 9'd400, 16'hAAAA, 1, 0};
`endif
      vecs[3] = '{9'd5,   9'd5,   9'd7,   9'd7,   16'h1234, 0, 18};
      vecs[4] = '{9'd0,   9'd0,   9'd0,   9'd3,   16'hFFFF, 0, 21};
      vecs[5] = '{9'd0,   9'd0,   9'd5,   9'd4,   16'h5555, 1, 0};
      vecs[6] = '{9'd236, 9'd239, 9'd398, 9'd399, 16'hBEEF, 0, 25};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", {wr_req, is_cmd, busy, done, err, cmd_out, data_out}, 0);
      init_done = 1'b1;

      for (int v = 0; v < 8; v++) begin
         clear_mon();
         build_exp(vecs[v].x0, vecs[v].x1, vecs[v].y0, vecs[v].y1, vecs[v].color);
         launch(vecs[v].x0, vecs[v].x1, vecs[v].y0, vecs[v].y1, vecs[v].color);
         check($sformatf("v%0d_busy_on", v), busy, 1);
         wait_end($sformatf("v%0d", v));
         check($sformatf("v%0d_err", v), err_cnt, vecs[v].exp_err);
         check($sformatf("v%0d_done", v), done_cnt, (vecs[v].exp_err != 0) ? 0 : 1);
         check($sformatf("v%0d_xfers", v), wr_cnt, vecs[v].exp_xfers);
         check_seq($sformatf("v%0d_seq", v));
         check($sformatf("v%0d_busy_off", v), busy, 0);
      end

      // Back-pressure: controller busy for 5 cycles after every transfer.
      clear_mon();
      busy_mode = 1;
      build_exp(9'd0, 9'd1, 9'd0, 9'd1, 16'hF800);
      launch(9'd0, 9'd1, 9'd0, 9'd1, 16'hF800);
      wait_end("bp");
      busy_mode = 0;
      repeat (8) @(posedge clk);
      check("bp_xfers", wr_cnt, 21);
      check("bp_viol", viol_cnt, 0);
      check("bp_done", done_cnt, 1);
      check_seq("bp_seq");

      // Reset in the middle of a full-panel fill, after 30 pixels.
      clear_mon();
      launch(9'd0, 9'd239, 9'd0, 9'd399, 16'h0F0F);
      begin
         int n;
         n = 0;
         while (wr_cnt < 47 && n < 2000) begin
            @(posedge clk);
            n++;
         end
         check("mid_timeout", (n >= 2000) ? 1 : 0, 0);
      end
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_outputs", {wr_req, is_cmd, busy, done, err, cmd_out, data_out}, 0);
      rst = 1'b0;
      clear_mon();
      repeat (10) @(posedge clk);
      check("mid_no_resume", wr_cnt + busy_cycles, 0);
      build_exp(9'd0, 9'd1, 9'd0, 9'd1, 16'h4321);
      launch(9'd0, 9'd1, 9'd0, 9'd1, 16'h4321);
      wait_end("post_rst");
      check("post_rst_done", done_cnt, 1);
      check_seq("post_rst_seq");

      // Start while uninitialised, then a second start (and init_done drop) during a fill.
      clear_mon();
      init_done = 1'b0;
      @(posedge clk);
      #1;
      x0 = 9'd0; x1 = 9'd1; y0 = 9'd0; y1 = 9'd0; start = 1'b1;
      repeat (4) @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      check("noinit_idle", wr_cnt + busy_cycles + err_cnt, 0);
      init_done = 1'b1;
      clear_mon();
      build_exp(9'd0, 9'd3, 9'd0, 9'd0, 16'hC0DE);
      launch(9'd0, 9'd3, 9'd0, 9'd0, 16'hC0DE);
      repeat (10) @(posedge clk);
      #1;
      x0 = 9'd100; x1 = 9'd120; y0 = 9'd3; y1 = 9'd9; color = 16'hDEAD;
      start = 1'b1; init_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 start = 1'b0;
      wait_end("restart");
      repeat (20) @(posedge clk);
      check("restart_done", done_cnt, 1);
      check("restart_err", err_cnt, 0);
      check_seq("restart_seq");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
